// File: rtl/cross_mul_arbiter_if.sv
// Requester-side bus of the shared cross-term unit.
// Operand buses are flat: requester i owns slice [i*W +: W] of req_a..req_d.
interface cross_mul_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int W       = 10
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ*W-1:0] req_c;
  logic [NUM_REQ*W-1:0] req_d;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [2*W+1:0]       resp_data;

  modport master (
    output req_valid, req_lock, req_a, req_b, req_c, req_d,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_lock, req_a, req_b, req_c, req_d,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/cross_mul_arbiter.sv
// cross_mul_arbiter: round-robin (or fixed-priority) arbiter in front of one
// pipelined signed cross-term unit P = (A-B)*(C-D), latency 2, one op/cycle.
// A requester may lock the unit so both halves of a cross product issue
// back to back.
// Optional feature: define CMA_FIXED_PRIO_EN for lowest-index-wins
// arbitration instead of round-robin (lock behaviour is unchanged).
module cross_mul_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 10
) (
  input  logic               clk,
  input  logic               reset,
  cross_mul_arbiter_if.slave bus
);
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW     = W + 1;
  localparam int PW     = 2 * W + 2;
  localparam int STAGES = 2;

  typedef enum logic {ARB, LOCK} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     cand;
  logic              accept;

  logic [NUM_REQ-1:0][W-1:0] a_v, b_v, c_v, d_v;

  logic [STAGES:1]           vld_pipe_q, vld_pipe_d;
  logic [STAGES:1][IW-1:0]   tag_q, tag_d;
  logic signed [DW-1:0]      da_q, da_d, dc_q, dc_d;
  logic signed [PW-1:0]      p_q, p_d;

  assign a_v = bus.req_a;
  assign b_v = bus.req_b;
  assign c_v = bus.req_c;
  assign d_v = bus.req_d;

  // Grant select: owner only while locked, otherwise search the valid requesters.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == LOCK) begin
      gnt_vld = bus.req_valid[owner_q];
      gnt_idx = owner_q;
    end else begin
`ifdef CMA_FIXED_PRIO_EN
      // Reverse scan so the lowest index is the last (winning) assignment.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = IW'(k);
        if (bus.req_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
`else
      // Reverse scan from rr_ptr so the nearest requester at/after it wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (bus.req_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
`endif
    end
  end

  // Ready is the one-hot grant; a grant only exists when that requester is valid.
  always_comb begin
    bus.req_ready = '0;
    if (gnt_vld) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign accept = gnt_vld;

  // Next arbitration state: pointer advance, lock capture and release.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (state_q == ARB) begin
`ifndef CMA_FIXED_PRIO_EN
        rr_ptr_d = IW'((int'(gnt_idx) + 1) % NUM_REQ);
`endif
        if (bus.req_lock[gnt_idx]) begin
          state_d = LOCK;
          owner_d = gnt_idx;
        end
      end else if (!bus.req_lock[gnt_idx]) begin
        state_d = ARB;
      end
    end
  end

  // Datapath next values: zero-extend then subtract gives W+1-bit signed differences.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], accept};
    tag_d      = {tag_q[STAGES-1:1], gnt_idx};
    da_d       = da_q;
    dc_d       = dc_q;
    p_d        = p_q;
    if (accept) begin
      da_d = {1'b0, a_v[gnt_idx]} - {1'b0, b_v[gnt_idx]};
      dc_d = {1'b0, c_v[gnt_idx]} - {1'b0, d_v[gnt_idx]};
    end
    // Full-range (W+1)x(W+1) signed product always fits in 2W+2 bits.
    if (vld_pipe_q[1]) p_d = da_q * dc_q;
  end

  // Response strobe follows the tag of the op leaving stage 2.
  always_comb begin
    bus.resp_valid = '0;
    if (vld_pipe_q[STAGES]) bus.resp_valid[tag_q[STAGES]] = 1'b1;
  end

  assign bus.resp_data = p_q;

  // State and pipeline registers; reset flushes in-flight ops and drops any lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      vld_pipe_q <= '0;
      tag_q      <= '0;
      da_q       <= '0;
      dc_q       <= '0;
      p_q        <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      vld_pipe_q <= vld_pipe_d;
      tag_q      <= tag_d;
      da_q       <= da_d;
      dc_q       <= dc_d;
      p_q        <= p_d;
    end
  end
endmodule
